// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency instruction BRAM,
// and resolves branch/jump redirects for a single-cycle core.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_ADDR_W = 14,
    parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   branch,
    input  logic [2:0]             branch_type,
    input  logic                   jump,
    input  logic                   jrn,
    input  logic [31:0]            rs1_data,
    input  logic [31:0]            rs2_data,
    input  logic [31:0]            imm32,
    input  logic [31:0]            imem_rdata,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [31:0]            inst,
    output logic                   inst_valid,
    output logic [31:0]            pc,
    output logic [31:0]            pc_plus4,
    output logic                   redirect,
    output logic                   misalign
);

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic [31:0] jalr_sum;
    logic [31:0] raw_target;
    logic [31:0] target;
    logic        taken;
    logic        redirect_c;
    logic        mis_q;
    logic        mis_set;

    always_comb begin
        taken = 1'b0;
        case (branch_type)
            3'b000:  taken = (rs1_data == rs2_data);
            3'b001:  taken = (rs1_data != rs2_data);
            3'b100:  taken = ($signed(rs1_data) < $signed(rs2_data));
            3'b101:  taken = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  taken = (rs1_data < rs2_data);
            3'b111:  taken = (rs1_data >= rs2_data);
            default: taken = 1'b0;
        endcase
    end

    // JAL and branches share pc+imm, so jump-over-branch priority only matters for JALR
    always_comb begin
        jalr_sum   = rs1_data + imm32;
        raw_target = pc_q + imm32;
        if (jump && jrn) begin
            raw_target = jalr_sum & ~32'h1;
        end
        target = raw_target;
        if (raw_target[1]) begin
            target = {raw_target[31:2], 2'b00};
        end
    end

    always_comb begin
        state_nx   = RUN;
        next_pc    = RESET_PC;
        redirect_c = 1'b0;
        mis_set    = 1'b0;
        case (state)
            BOOT: begin
                state_nx = RUN;
                next_pc  = RESET_PC;
            end
            RUN: begin
                state_nx = RUN;
                if (stall) begin
                    next_pc = pc_q;
                end else if (jump || (branch && taken)) begin
                    redirect_c = 1'b1;
                    next_pc    = target;
                    mis_set    = raw_target[1];
                end else begin
                    next_pc = pc_q + 32'd4;
                end
            end
            default: begin
                state_nx = BOOT;
                next_pc  = RESET_PC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            pc_q  <= RESET_PC;
            mis_q <= 1'b0;
        end else begin
            state <= state_nx;
            pc_q  <= next_pc;
            if (mis_set) begin
                mis_q <= 1'b1;
            end
        end
    end

    assign imem_addr  = next_pc[IMEM_ADDR_W+1:2];
    assign inst       = (state == RUN) ? imem_rdata : NOP_INST;
    assign inst_valid = (state == RUN);
    assign pc         = pc_q;
    assign pc_plus4   = pc_q + 32'd4;
    assign redirect   = redirect_c;
    assign misalign   = mis_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a BRAM model and a PC-level reference model.
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          AW       = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic          branch = 1'b0;
    logic [2:0]    branch_type = 3'b000;
    logic          jump = 1'b0;
    logic          jrn = 1'b0;
    logic [31:0]   rs1_data = '0;
    logic [31:0]   rs2_data = '0;
    logic [31:0]   imm32 = '0;
    logic [31:0]   imem_rdata = '0;
    logic [AW-1:0] imem_addr;
    logic [31:0]   inst;
    logic          inst_valid;
    logic [31:0]   pc;
    logic [31:0]   pc_plus4;
    logic          redirect;
    logic          misalign;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] mem [0:(1<<AW)-1];

    ifetch_unit #(
        .RESET_PC(RESET_PC),
        .IMEM_ADDR_W(AW),
        .NOP_INST(NOP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .branch(branch),
        .branch_type(branch_type),
        .jump(jump),
        .jrn(jrn),
        .rs1_data(rs1_data),
        .rs2_data(rs2_data),
        .imm32(imm32),
        .imem_rdata(imem_rdata),
        .imem_addr(imem_addr),
        .inst(inst),
        .inst_valid(inst_valid),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .redirect(redirect),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= mem[imem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural PC, run flag and sticky misalign flag
    logic [31:0] m_pc = RESET_PC;
    logic        m_run = 1'b0;
    logic        m_mis = 1'b0;

    function automatic logic is_taken(input logic [2:0] bt, input logic [31:0] a,
                                      input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (bt == 3'd0) return a == b;
        if (bt == 3'd1) return a != b;
        if (bt == 3'd4) return sa < sb;
        if (bt == 3'd5) return sa >= sb;
        if (bt == 3'd6) return a < b;
        if (bt == 3'd7) return a >= b;
        return 1'b0;
    endfunction

    function automatic logic m_redirect();
        return m_run && !stall && (jump || (branch && is_taken(branch_type, rs1_data, rs2_data)));
    endfunction

    function automatic logic [31:0] m_raw_target();
        if (jump && jrn) return (rs1_data + imm32) & 32'hFFFF_FFFE;
        return m_pc + imm32;
    endfunction

    function automatic logic [31:0] m_next();
        logic [31:0] t;
        if (!m_run) return RESET_PC;
        if (stall) return m_pc;
        if (!m_redirect()) return m_pc + 32'd4;
        t = m_raw_target();
        if (t[1]) t[1:0] = 2'b00;
        return t;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc  = RESET_PC;
            m_run = 1'b0;
            m_mis = 1'b0;
        end else begin
            logic [31:0] nx;
            logic        set_mis;
            nx      = m_next();
            set_mis = m_redirect() && m_raw_target()[1];
            m_run   = 1'b1;
            m_pc    = nx;
            if (set_mis) m_mis = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [31:0] nx;
        nx = m_next();
        check("cmp_pc", pc, m_pc);
        check("cmp_pc_plus4", pc_plus4, m_pc + 32'd4);
        check("cmp_valid", {31'd0, inst_valid}, {31'd0, m_run});
        check("cmp_inst", inst, m_run ? mem[m_pc[AW+1:2]] : NOP);
        check("cmp_redirect", {31'd0, redirect}, {31'd0, m_redirect()});
        check("cmp_misalign", {31'd0, misalign}, {31'd0, m_mis});
        check("cmp_imem_addr", {18'd0, imem_addr}, {18'd0, nx[AW+1:2]});
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h1000_0000 | i;
        mem[0] = 32'h0050_0093;

        repeat (2) tick();
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, NOP);
        check("rst_imem_addr", {18'd0, imem_addr}, 32'd0);

        rst_n = 1'b1;
        #1;
        check("boot_inst", inst, 32'h0000_0013);
        check("boot_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check("c1_inst", inst, 32'h0050_0093);
        check("c1_pc", pc, 32'h0);
        check("c1_valid", {31'd0, inst_valid}, 32'd1);
        tick();
        check("c2_pc", pc, 32'h4);
        tick();
        tick();
        tick();
        check("line_pc16", pc, 32'h10);
        check("line_pp4", pc_plus4, 32'h14);

        branch = 1'b1;
        branch_type = 3'b000;
        rs1_data = 32'd7;
        rs2_data = 32'd7;
        imm32 = 32'hFFFF_FFF8;
        #1;
        check("beq_redir", {31'd0, redirect}, 32'd1);
        tick();
        branch = 1'b0;
        check("beq_taken_pc", pc, 32'h08);
        tick();
        tick();
        branch = 1'b1;
        rs2_data = 32'd8;
        #1;
        check("beq_nt_redir", {31'd0, redirect}, 32'd0);
        tick();
        check("beq_nt_pc", pc, 32'h14);

        branch_type = 3'b100;
        rs1_data = 32'hFFFF_FFFF;
        rs2_data = 32'd1;
        imm32 = 32'h20;
        tick();
        check("blt_pc", pc, 32'h34);
        branch_type = 3'b110;
        tick();
        check("bltu_pc", pc, 32'h38);
        branch = 1'b0;
        tick();

        jump = 1'b1;
        jrn = 1'b1;
        rs1_data = 32'h101;
        imm32 = 32'h20;
        #1;
        check("jalr_link", pc_plus4, 32'h40);
        tick();
        check("jalr_pc", pc, 32'h120);
        check("jalr_mis0", {31'd0, misalign}, 32'd0);
        rs1_data = 32'h102;
        imm32 = 32'h0;
        tick();
        check("mis_pc", pc, 32'h100);
        check("mis_set", {31'd0, misalign}, 32'd1);
        jump = 1'b0;
        jrn = 1'b0;
        tick();
        check("mis_sticky", {31'd0, misalign}, 32'd1);
        check("mis_next_pc", pc, 32'h104);

        jump = 1'b1;
        imm32 = 32'hFFFF_FF08;
        tick();
        check("jal_back_pc", pc, 32'h0C);
        imm32 = 32'h40;
        stall = 1'b1;
        #1;
        check("stall_noredir", {31'd0, redirect}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_pc", pc, 32'h0C);
            check("stall_inst", inst, 32'h1000_0003);
        end
        stall = 1'b0;
        #1;
        check("unstall_redir", {31'd0, redirect}, 32'd1);
        tick();
        check("unstall_pc", pc, 32'h4C);

        jrn = 1'b1;
        branch = 1'b1;
        branch_type = 3'b000;
        rs1_data = 32'h200;
        rs2_data = 32'h200;
        imm32 = 32'h10;
        tick();
        check("jump_wins_pc", pc, 32'h210);
        branch = 1'b0;
        jrn = 1'b0;
        imm32 = 32'hFFFF_FDEC;
        #1;
        check("wrap_addr", {18'd0, imem_addr}, 32'h3FFF);
        tick();
        jump = 1'b0;
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        check("wrap_inst", inst, 32'h1000_3FFF);
        tick();
        check("wrap_pc0", pc, 32'h0);
        tick();

        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_pc", pc, 32'h0);
        check("midrst_valid", {31'd0, inst_valid}, 32'd0);
        check("midrst_mis", {31'd0, misalign}, 32'd0);
        check("midrst_inst", inst, NOP);
        tick();
        rst_n = 1'b1;
        #1;
        check("reboot_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check("reboot_run_pc", pc, 32'h0);
        check("reboot_run_inst", inst, 32'h0050_0093);
        tick();
        check("reboot_pc4", pc, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
